// File: rtl/star_box_responder_pkg.sv
// Shared sizes, state/mode encodings and small helpers for the star box responder.
// Image is IMG_W x IMG_H pixels stored row-major in the image RAM.
package star_box_responder_pkg;

    localparam int XSZ     = 3;
    localparam int YSZ     = 3;
    localparam int ADDR_SZ = 6;
    localparam int COL_SZ  = 3;
    localparam int IMG_W   = 6;
    localparam int IMG_H   = 6;

    localparam logic [COL_SZ-1:0] BOX_COL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SCAN = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic {
        MODE_DRAW  = 1'b0,
        MODE_CLEAN = 1'b1
    } mode_t;

    function automatic logic [XSZ-1:0] clip_x(input logic [XSZ-1:0] v);
        logic [XSZ-1:0] lim;
        lim = XSZ'(IMG_W - 1);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [YSZ-1:0] clip_y(input logic [YSZ-1:0] v);
        logic [YSZ-1:0] lim;
        lim = YSZ'(IMG_H - 1);
        return (v > lim) ? lim : v;
    endfunction

    // Row-major address, wrapped to the RAM address width.
    function automatic logic [ADDR_SZ-1:0] pix_addr(input logic [YSZ-1:0] y,
                                                    input logic [XSZ-1:0] x);
        return ADDR_SZ'(y) * ADDR_SZ'(IMG_W) + ADDR_SZ'(x);
    endfunction

endpackage

// File: rtl/star_box_responder_if.sv
// Request/response bundle between the scan FSM (master) and the box responder (slave),
// plus the VGA and image-RAM write buses the responder drives.
interface star_box_responder_if;
    import star_box_responder_pkg::*;

    logic               goDraw;
    logic               goClean;
    logic [YSZ-1:0]     top;
    logic [YSZ-1:0]     bottom;
    logic [XSZ-1:0]     left;
    logic [XSZ-1:0]     right;
    logic [7:0]         vgaX;
    logic [6:0]         vgaY;
    logic [COL_SZ-1:0]  vgaColour;
    logic               plot;
    logic [ADDR_SZ-1:0] memAddr;
    logic [COL_SZ-1:0]  memData;
    logic               memWren;
    logic               doneDraw;
    logic               doneClean;

    modport master (
        output goDraw, goClean, top, bottom, left, right,
        input  vgaX, vgaY, vgaColour, plot, memAddr, memData, memWren, doneDraw, doneClean
    );

    modport slave (
        input  goDraw, goClean, top, bottom, left, right,
        output vgaX, vgaY, vgaColour, plot, memAddr, memData, memWren, doneDraw, doneClean
    );

endinterface

// File: rtl/star_box_responder_raster.sv
// Raster x/y walker over an inclusive box: load to a corner, step x fastest,
// wrap x back to left at the right edge and flag the final pixel.
module box_raster_counter
    import star_box_responder_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [XSZ-1:0] load_x_i,
    input  logic [YSZ-1:0] load_y_i,
    input  logic [XSZ-1:0] left_i,
    input  logic [XSZ-1:0] right_i,
    input  logic [YSZ-1:0] bottom_i,
    output logic [XSZ-1:0] x_o,
    output logic [YSZ-1:0] y_o,
    output logic           last_o
);

    logic [XSZ-1:0] x_q, x_d;
    logic [YSZ-1:0] y_q, y_d;

    // Next position: load wins over step, otherwise hold.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = load_x_i;
            y_d = load_y_i;
        end else if (step_i) begin
            if (x_q == right_i) begin
                x_d = left_i;
                y_d = y_q + YSZ'(1);
            end else begin
                x_d = x_q + XSZ'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == right_i) && (y_q == bottom_i);

endmodule

// File: rtl/star_box_responder.sv
// Services goDraw (box outline to VGA) and goClean (zero the box in image RAM),
// answering each with a one-cycle done pulse.
module star_box_responder
    import star_box_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    star_box_responder_if.slave  bus
);

    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic           go_draw_q, go_clean_q;
    logic [YSZ-1:0] top_q, bottom_q;
    logic [XSZ-1:0] left_q, right_q;

    logic [YSZ-1:0] top_clip, bottom_clip;
    logic [XSZ-1:0] left_clip, right_clip;
    logic [XSZ-1:0] x;
    logic [YSZ-1:0] y;
    logic           last_pix;
    logic           draw_rise, clean_rise;
    logic           on_edge;

    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [COL_SZ-1:0]  vga_col;
    logic               plot;
    logic [ADDR_SZ-1:0] mem_addr;
    logic               mem_wren;
    logic               done_draw;
    logic               done_clean;

    assign top_clip    = clip_y(bus.top);
    assign bottom_clip = clip_y(bus.bottom);
    assign left_clip   = clip_x(bus.left);
    assign right_clip  = clip_x(bus.right);

    assign draw_rise  = bus.goDraw  & ~go_draw_q;
    assign clean_rise = bus.goClean & ~go_clean_q;

    box_raster_counter u_raster (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (state_q == ST_LOAD),
        .step_i   (state_q == ST_SCAN),
        .load_x_i (left_clip),
        .load_y_i (top_clip),
        .left_i   (left_q),
        .right_i  (right_q),
        .bottom_i (bottom_q),
        .x_o      (x),
        .y_o      (y),
        .last_o   (last_pix)
    );

    // State, mode, request history and the box copy used for the whole scan.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_DRAW;
            go_draw_q  <= 1'b0;
            go_clean_q <= 1'b0;
            top_q      <= '0;
            bottom_q   <= '0;
            left_q     <= '0;
            right_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            go_draw_q  <= bus.goDraw;
            go_clean_q <= bus.goClean;
            if (state_q == ST_LOAD) begin
                top_q    <= top_clip;
                bottom_q <= bottom_clip;
                left_q   <= left_clip;
                right_q  <= right_clip;
            end
        end
    end

    // Next state; only fresh request edges start work, draw has priority.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (draw_rise) begin
                    state_d = ST_LOAD;
                    mode_d  = MODE_DRAW;
                end else if (clean_rise) begin
                    state_d = ST_LOAD;
                    mode_d  = MODE_CLEAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if ((top_clip > bottom_clip) || (left_clip > right_clip)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_pix) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign on_edge = (x == left_q) || (x == right_q) || (y == top_q) || (y == bottom_q);

    // Outputs decode directly from state, mode and position so they line up with the pixel.
    always_comb begin
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_col    = '0;
        plot       = 1'b0;
        mem_addr   = '0;
        mem_wren   = 1'b0;
        done_draw  = 1'b0;
        done_clean = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (mode_q == MODE_DRAW) begin
                    vga_x   = 8'(x);
                    vga_y   = 7'(y);
                    plot    = on_edge;
                    vga_col = on_edge ? BOX_COL : '0;
                end else begin
                    mem_wren = 1'b1;
                    mem_addr = pix_addr(y, x);
                end
            end
            ST_DONE: begin
                done_draw  = (mode_q == MODE_DRAW);
                done_clean = (mode_q == MODE_CLEAN);
            end
            default: begin
                plot = 1'b0;
            end
        endcase
    end

    assign bus.vgaX      = vga_x;
    assign bus.vgaY      = vga_y;
    assign bus.vgaColour = vga_col;
    assign bus.plot      = plot;
    assign bus.memAddr   = mem_addr;
    assign bus.memData   = '0;
    assign bus.memWren   = mem_wren;
    assign bus.doneDraw  = done_draw;
    assign bus.doneClean = done_clean;

endmodule

// File: tb/tb_star_box_responder.sv
// Table-driven and randomized check of star_box_responder against a per-cycle
// model built from nested row/column loops over the clipped box.
module tb_star_box_responder;

    logic clk;
    logic resetn;

    star_box_responder_if bus_if ();

    star_box_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       plot;
        logic [7:0] vx;
        logic [6:0] vy;
        logic [2:0] col;
        logic       wren;
        logic [5:0] addr;
        logic [2:0] data;
        logic       dd;
        logic       dc;
    } obs_t;

    typedef struct {
        int t, b, l, r;
        bit gd, gc;
        int late_clean;
        int hold;
        int n_scan;
        int n_plot;
        int n_wr;
        int n_dd;
        int n_dc;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    int   wr_log[$];

    function automatic obs_t sample_obs();
        obs_t o;
        o.plot = bus_if.plot;
        o.vx   = bus_if.vgaX;
        o.vy   = bus_if.vgaY;
        o.col  = bus_if.vgaColour;
        o.wren = bus_if.memWren;
        o.addr = bus_if.memAddr;
        o.data = bus_if.memData;
        o.dd   = bus_if.doneDraw;
        o.dc   = bus_if.doneClean;
        return o;
    endfunction

    task automatic check_obs(input obs_t e, input string nm, input int cyc);
        obs_t g;
        g = sample_obs();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got plot=%b x=%0d y=%0d col=%0d wren=%b addr=%0d data=%0d dd=%b dc=%b, expected plot=%b x=%0d y=%0d col=%0d wren=%b addr=%0d data=%0d dd=%b dc=%b",
                     nm, cyc, g.plot, g.vx, g.vy, g.col, g.wren, g.addr, g.data, g.dd, g.dc,
                     e.plot, e.vx, e.vy, e.col, e.wren, e.addr, e.data, e.dd, e.dc);
        end
    endtask

    task automatic check_int(input int got, input int expv, input string nm);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    // Expected cycle stream: LOAD, each pixel in raster order, DONE, one idle cycle.
    task automatic build_model(input int t, input int b, input int l, input int r, input bit draw);
        int   tc, bc, lc, rc;
        obs_t e;
        tc = (t > 5) ? 5 : t;
        bc = (b > 5) ? 5 : b;
        lc = (l > 5) ? 5 : l;
        rc = (r > 5) ? 5 : r;
        exp_q.delete();
        exp_q.push_back('0);
        if (tc <= bc && lc <= rc) begin
            for (int yy = tc; yy <= bc; yy++) begin
                for (int xx = lc; xx <= rc; xx++) begin
                    e = '0;
                    if (draw) begin
                        e.plot = (xx == lc) || (xx == rc) || (yy == tc) || (yy == bc);
                        e.vx   = 8'(xx);
                        e.vy   = 7'(yy);
                        e.col  = e.plot ? 3'b100 : 3'b000;
                    end else begin
                        e.wren = 1'b1;
                        e.addr = 6'(yy * 6 + xx);
                    end
                    exp_q.push_back(e);
                end
            end
        end
        e = '0;
        if (draw) e.dd = 1'b1;
        else      e.dc = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back('0);
    endtask

    task automatic run_case(input vec_t v, input bit scramble, input string nm,
                            output int lat, output int np, output int nw,
                            output int ndd, output int ndc);
        obs_t g;
        lat = -1; np = 0; nw = 0; ndd = 0; ndc = 0;
        wr_log.delete();
        build_model(v.t, v.b, v.l, v.r, v.gd);
        @(negedge clk);
        bus_if.top     = 3'(v.t);
        bus_if.bottom  = 3'(v.b);
        bus_if.left    = 3'(v.l);
        bus_if.right   = 3'(v.r);
        bus_if.goDraw  = v.gd;
        bus_if.goClean = v.gc;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            g = sample_obs();
            check_obs(exp_q[k], nm, k + 1);
            if (g.plot) np++;
            if (g.wren) begin
                nw++;
                wr_log.push_back(int'(g.addr));
            end
            if (g.dd) ndd++;
            if (g.dc) ndc++;
            if ((g.dd || g.dc) && lat < 0) lat = k + 1;
            if (k == v.late_clean) bus_if.goClean = 1'b1;
            if (scramble && k >= 1) begin
                bus_if.top    = 3'($urandom_range(0, 7));
                bus_if.bottom = 3'($urandom_range(0, 7));
                bus_if.left   = 3'($urandom_range(0, 7));
                bus_if.right  = 3'($urandom_range(0, 7));
            end
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            g = sample_obs();
            if (g.dd) ndd++;
            if (g.dc) ndc++;
            check_obs('0, {nm, "_hold"}, h);
        end
        bus_if.goDraw  = 1'b0;
        bus_if.goClean = 1'b0;
        @(negedge clk);
        check_obs('0, {nm, "_idle"}, 0);
    endtask

    vec_t vecs[11];
    int   addr_ref[9];
    obs_t e3;

    initial begin
        int lat, np, nw, ndd, ndc;
        vec_t rv;

        //         t  b  l  r  gd gc late hold scan plot wr dd dc
        vecs[0]  = '{1, 3, 2, 4, 1, 0, -1,  0,  9,  8,  0, 1, 0};
        vecs[1]  = '{1, 3, 2, 4, 0, 1, -1,  0,  9,  0,  9, 0, 1};
        vecs[2]  = '{5, 5, 5, 5, 1, 0, -1,  0,  1,  1,  0, 1, 0};
        vecs[3]  = '{5, 5, 5, 5, 0, 1, -1,  0,  1,  0,  1, 0, 1};
        vecs[4]  = '{4, 2, 0, 5, 1, 0, -1, 20,  0,  0,  0, 1, 0};
        vecs[5]  = '{1, 3, 2, 4, 1, 1, -1,  5,  9,  8,  0, 1, 0};
        vecs[6]  = '{7, 7, 6, 7, 1, 0, -1,  0,  1,  1,  0, 1, 0};
        vecs[7]  = '{0, 5, 0, 5, 0, 1, -1,  0, 36,  0, 36, 0, 1};
        vecs[8]  = '{2, 2, 1, 4, 1, 0, -1,  0,  4,  4,  0, 1, 0};
        vecs[9]  = '{0, 1, 3, 1, 0, 1, -1,  0,  0,  0,  0, 0, 1};
        vecs[10] = '{1, 3, 2, 4, 1, 0,  4,  5,  9,  8,  0, 1, 0};
        addr_ref = '{8, 9, 10, 14, 15, 16, 20, 21, 22};

        resetn         = 1'b0;
        bus_if.goDraw  = 1'b0;
        bus_if.goClean = 1'b0;
        bus_if.top     = 3'd0;
        bus_if.bottom  = 3'd0;
        bus_if.left    = 3'd0;
        bus_if.right   = 3'd0;
        repeat (2) @(negedge clk);
        check_obs('0, "reset", 0);
        resetn = 1'b1;
        @(negedge clk);
        check_obs('0, "idle_after_reset", 0);

        for (int i = 0; i < 11; i++) begin
            run_case(vecs[i], 1'b0, $sformatf("vec%0d", i), lat, np, nw, ndd, ndc);
            check_int(lat, vecs[i].n_scan + 2, $sformatf("vec%0d_latency", i));
            check_int(np,  vecs[i].n_plot,     $sformatf("vec%0d_plots", i));
            check_int(nw,  vecs[i].n_wr,       $sformatf("vec%0d_writes", i));
            check_int(ndd, vecs[i].n_dd,       $sformatf("vec%0d_doneDraw", i));
            check_int(ndc, vecs[i].n_dc,       $sformatf("vec%0d_doneClean", i));
            if (i == 1) begin
                for (int j = 0; j < 9; j++) begin
                    check_int((j < wr_log.size()) ? wr_log[j] : -1, addr_ref[j],
                              $sformatf("clean_addr%0d", j));
                end
            end
        end

        // Reset during the third SCAN cycle: outputs drop next cycle, no done.
        @(negedge clk);
        bus_if.top    = 3'd1;
        bus_if.bottom = 3'd3;
        bus_if.left   = 3'd2;
        bus_if.right  = 3'd4;
        bus_if.goDraw = 1'b1;
        repeat (4) @(negedge clk);
        e3      = '0;
        e3.plot = 1'b1;
        e3.vx   = 8'd4;
        e3.vy   = 7'd1;
        e3.col  = 3'b100;
        check_obs(e3, "rst_scan3", 4);
        resetn        = 1'b0;
        bus_if.goDraw = 1'b0;
        @(negedge clk);
        check_obs('0, "rst_mid", 0);
        resetn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check_obs('0, "rst_no_done", k);
        end
        run_case(vecs[0], 1'b0, "after_rst", lat, np, nw, ndd, ndc);
        check_int(lat, 11, "after_rst_latency");
        check_int(ndd, 1,  "after_rst_doneDraw");

        // Random boxes and modes; corners are scrambled once the box is latched.
        for (int i = 0; i < 30; i++) begin
            rv.t = int'($urandom_range(0, 7));
            rv.b = int'($urandom_range(0, 7));
            rv.l = int'($urandom_range(0, 7));
            rv.r = int'($urandom_range(0, 7));
            rv.gd = bit'($urandom_range(0, 1));
            rv.gc = ~rv.gd | bit'($urandom_range(0, 1));
            rv.late_clean = -1;
            rv.hold = 0;
            rv.n_scan = 0; rv.n_plot = 0; rv.n_wr = 0; rv.n_dd = 0; rv.n_dc = 0;
            run_case(rv, 1'b1, $sformatf("rand%0d", i), lat, np, nw, ndd, ndc);
            check_int(ndd + ndc, 1, $sformatf("rand%0d_one_done", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
